// File: rtl/airlock_pkg.sv
// Shared definitions for the airlock sequencer: FSM state codes and timer width.
package airlock_pkg;

    localparam int TIMER_W = 4;

    typedef enum logic [2:0] {
        EVAC_IDLE  = 3'd0,
        OUTER_OPEN = 3'd1,
        FILLING    = 3'd2,
        PRESS_IDLE = 3'd3,
        INNER_OPEN = 3'd4,
        EVACUATING = 3'd5
    } state_t;

endpackage

// File: rtl/tick_timer.sv
// Loadable 4-bit down-counter advanced by tick; done flags the tick that empties it.
module tick_timer
    import airlock_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               tick,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    // A load beats a coincident tick, so that tick is not counted.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = tick && (count <= TIMER_W'(1));

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock port/pressure sequencer. Define AIRLOCK_AUTOCLOSE_EN to close open ports
// automatically after CLOSE_TICKS ticks.
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int PRESS_TICKS = 7,
    parameter int EVAC_TICKS  = 8,
    parameter int CLOSE_TICKS = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       outer_req,
    input  logic       inner_req,
    input  logic       fill_req,
    input  logic       evac_req,
    output logic       outer_open,
    output logic       inner_open,
    output logic       pressurized,
    output logic       busy,
    output logic       reject,
    output logic [2:0] state
);

`ifdef AIRLOCK_AUTOCLOSE_EN
    localparam bit AUTOCLOSE = 1'b1;
`else
    localparam bit AUTOCLOSE = 1'b0;
`endif

    state_t             state_q;
    state_t             state_d;
    logic               reject_q;
    logic               reject_d;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_done;
    logic [3:0]         req_vec;
    logic [3:0]         legal_vec;
    logic [3:0]         cand_vec;
    logic [3:0]         grant_vec;

    tick_timer u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (tick),
        .done       (timer_done)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= EVAC_IDLE;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reject_q <= reject_d;
        end
    end

    // Bit order is request priority: outer, inner, fill, evac.
    always_comb begin
        req_vec   = {outer_req, inner_req, fill_req, evac_req};
        legal_vec = 4'b0000;
        case (state_q)
            EVAC_IDLE:  legal_vec = 4'b1010;
            OUTER_OPEN: legal_vec = 4'b1000;
            PRESS_IDLE: legal_vec = 4'b0101;
            INNER_OPEN: legal_vec = 4'b0100;
            default:    legal_vec = 4'b0000;
        endcase
        cand_vec  = req_vec & legal_vec;
        grant_vec = 4'b0000;
        if (cand_vec[3]) begin
            grant_vec = 4'b1000;
        end else if (cand_vec[2]) begin
            grant_vec = 4'b0100;
        end else if (cand_vec[1]) begin
            grant_vec = 4'b0010;
        end else if (cand_vec[0]) begin
            grant_vec = 4'b0001;
        end
        reject_d = |(req_vec & ~grant_vec);
    end

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            EVAC_IDLE: begin
                if (grant_vec[3]) begin
                    state_d    = OUTER_OPEN;
                    timer_load = AUTOCLOSE;
                end else if (grant_vec[1]) begin
                    state_d    = FILLING;
                    timer_load = 1'b1;
                end
            end
            OUTER_OPEN: begin
                if (grant_vec[3] || (AUTOCLOSE && timer_done)) begin
                    state_d = EVAC_IDLE;
                end
            end
            FILLING: begin
                if (timer_done) begin
                    state_d = PRESS_IDLE;
                end
            end
            PRESS_IDLE: begin
                if (grant_vec[2]) begin
                    state_d    = INNER_OPEN;
                    timer_load = AUTOCLOSE;
                end else if (grant_vec[0]) begin
                    state_d    = EVACUATING;
                    timer_load = 1'b1;
                end
            end
            INNER_OPEN: begin
                if (grant_vec[2] || (AUTOCLOSE && timer_done)) begin
                    state_d = PRESS_IDLE;
                end
            end
            EVACUATING: begin
                if (timer_done) begin
                    state_d = EVAC_IDLE;
                end
            end
            default: state_d = EVAC_IDLE;
        endcase
    end

    // The close value is only ever loaded when auto-close is built in.
    always_comb begin
        case (state_d)
            FILLING:    timer_value = TIMER_W'(PRESS_TICKS);
            EVACUATING: timer_value = TIMER_W'(EVAC_TICKS);
            default:    timer_value = TIMER_W'(CLOSE_TICKS);
        endcase
    end

    assign outer_open  = (state_q == OUTER_OPEN);
    assign inner_open  = (state_q == INNER_OPEN);
    assign pressurized = (state_q == PRESS_IDLE) || (state_q == INNER_OPEN);
    assign busy        = (state_q == FILLING) || (state_q == EVACUATING);
    assign reject      = reject_q;
    assign state       = state_q;

endmodule

// File: doc/airlock_sequencer.md
AIRLOCK_SEQUENCER -- requirements
Module: airlock_sequencer

Interface
REQ-001 Parameter PRESS_TICKS, default 7, number of tick pulses needed to fill and pressurize the chamber (legal range 1..15).
REQ-002 Parameter EVAC_TICKS, default 8, number of tick pulses needed to evacuate the chamber (legal range 1..15).
REQ-003 Parameter CLOSE_TICKS, default 5, tick pulses before an open port auto-closes; used only with AIRLOCK_AUTOCLOSE_EN.
REQ-004 Clock  in  1  system clock; one clock, all logic on its rising edge.
REQ-005 Reset  in  1  synchronous, active-low reset.
REQ-006 tick  in  1  one-cycle timing strobe from the divided clock; timers advance only on cycles where tick=1.
REQ-007 outer_req  in  1  one-cycle pulse that toggles the outer port (open if closed, close if open).
REQ-008 inner_req  in  1  one-cycle pulse that toggles the inner port.
REQ-009 fill_req  in  1  one-cycle pulse that starts fill/pressurize.
REQ-010 evac_req  in  1  one-cycle pulse that starts evacuation.
REQ-011 outer_open, inner_open  out  1 each  port open drive (1=open).
REQ-012 pressurized  out  1  chamber at inner-side pressure.
REQ-013 busy  out  1  fill or evacuation in progress.
REQ-014 reject  out  1  one-cycle pulse when a request is refused.
REQ-015 state  out  3  current FSM state code, for the LEDR/HEX display.

Function
REQ-016 FSM states: EVAC_IDLE(0), OUTER_OPEN(1), FILLING(2), PRESS_IDLE(3), INNER_OPEN(4), EVACUATING(5); codes 6 and 7 are unused and shall return to EVAC_IDLE on the next clock.
REQ-017 EVAC_IDLE transitions: outer_req goes to OUTER_OPEN; fill_req goes to FILLING and loads the timer with PRESS_TICKS.
REQ-018 OUTER_OPEN: outer_req goes to EVAC_IDLE; any other request is rejected.
REQ-019 FILLING: on each tick the timer decrements; on the tick that reaches 0 the FSM goes to PRESS_IDLE, so PRESS_IDLE is entered on the clock after the PRESS_TICKS-th tick.
REQ-020 PRESS_IDLE transitions: inner_req goes to INNER_OPEN; evac_req goes to EVACUATING and loads the timer with EVAC_TICKS.
REQ-021 INNER_OPEN: inner_req goes to PRESS_IDLE; any other request is rejected.
REQ-022 EVACUATING behaves as FILLING, using EVAC_TICKS, and ends in EVAC_IDLE.
REQ-023 Any request that is not legal in the current state shall pulse reject for exactly one cycle, registered (the cycle after the request), and shall not change state.
REQ-024 All requests, including a repeat of the same request, are rejected while busy=1.
REQ-025 Simultaneous requests resolve in priority outer_req > inner_req > fill_req > evac_req: only the highest legal request acts; every other asserted request pulses reject once.
REQ-026 Outputs are decoded from the registered state, with zero latency from state to outputs:
- outer_open=1 only in OUTER_OPEN.
- inner_open=1 only in INNER_OPEN.
- pressurized=1 in PRESS_IDLE and INNER_OPEN.
- busy=1 in FILLING and EVACUATING.
REQ-027 outer_open and inner_open shall never both be 1 in any cycle; this is an invariant.
REQ-028 The timer is 4 bits wide and never wraps below 0.
REQ-029 tick asserted in the same cycle as the request that loads the timer does not count.

Reset
REQ-030 While Reset=0 at a clock edge:
- state becomes EVAC_IDLE and the timer becomes 0.
- All outputs become 0 (including reject), and state=0.
REQ-031 Reset asserted mid-fill or mid-evacuation aborts the operation immediately; no pending reject is emitted after reset.

Configuration
REQ-032 Macro AIRLOCK_AUTOCLOSE_EN, when defined: in OUTER_OPEN or INNER_OPEN the timer loads CLOSE_TICKS on entry, and the port closes automatically after CLOSE_TICKS ticks, returning to EVAC_IDLE or PRESS_IDLE respectively, with no reject pulse.
REQ-033 Without the macro, ports stay open until explicitly toggled, and CLOSE_TICKS is unused.

Structure
REQ-034 The state encodings and the 4-bit timer width constant live in the shared package airlock_pkg.
REQ-035 One sub-module, tick_timer: a loadable 4-bit down-counter with tick enable and a done output, used for fill, evacuation and auto-close.

Verification
REQ-036 Reset, then fill_req with tick every 4th cycle -> busy=1 for 7 ticks; then pressurized=1, state=3.
REQ-037 From EVAC_IDLE, inner_req -> reject pulses 1 cycle, state stays 0, inner_open=0.
REQ-038 In OUTER_OPEN, fill_req and inner_req in the same cycle -> two reject pulses are not required, one reject pulse is emitted, and outer_open stays 1.
REQ-039 From EVAC_IDLE, outer_req and fill_req in the same cycle -> OUTER_OPEN is entered and reject pulses once.
REQ-040 During EVACUATING at tick 3 of 8, Reset=0 for 1 cycle -> state=0, busy=0, and the next fill_req is accepted.
REQ-041 With AIRLOCK_AUTOCLOSE_EN, inner_req from PRESS_IDLE -> inner_open=1 for 5 ticks, then 0, state=3; a random-stimulus assertion holds !(outer_open && inner_open) throughout.
